multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Sequencing FSM for the RV32I multicycle core. Decodes the IR opcode and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Drives all datapath strobes, including the format select for the immediate generator. Also counts retired instructions and halts on a qualifying ECALL.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0]; stable from DECODE until the instruction retires
- funct3  in  3  IR[14:12]; used only for immediate selection
- mem_ready  in  1  memory handshake; the access completes in the cycle this is high
- bcond  in  1  branch condition from the ALU; valid in EXEC
- halt_cond  in  1  high when x17 == 10; valid in EXEC
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_write  out  1  register file write enable
- wb_sel  out  2  write-back source: 00 ALU, 01 MDR, 10 PC+4
- alu_src_b  out  1  ALU B operand: 0 = rs2, 1 = imm
- alu_op  out  2  ALU operation: 00 ADD, 01 branch compare, 10 funct-decoded
- imm_sel  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 shamt
- pc_write  out  1  PC load enable
- pc_source  out  2  next-PC source: 00 PC+4, 01 ALU result (JALR), 10 PC+imm
- retired  out  1  one-cycle pulse, equal to pc_write
- instr_count  out  CNT_W  number of retired instructions
- is_halted  out  1  sticky halt flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. 3-bit registered state.
- All outputs are combinational from the state and opcode. Any output not listed for a state is 0.
- FETCH: i_or_d=0, mem_read=1, ir_write=mem_ready. Go to DECODE when mem_ready is high; otherwise stay in FETCH.
- DECODE: no strobes. Always go to EXEC.
- EXEC, by opcode:
  - ARITHMETIC (0110011): alu_op=10, alu_src_b=0. Go to WB.
  - ARITHMETIC_IMM (0010011): alu_op=10, alu_src_b=1. imm_sel=5 when funct3 is SLL or SRL/SRA, otherwise 0. Go to WB.
  - LOAD (0000011): alu_op=00, alu_src_b=1, imm_sel=0. Go to MEM.
  - STORE (0100011): alu_op=00, alu_src_b=1, imm_sel=1. Go to MEM.
  - BRANCH (1100011): alu_op=01, imm_sel=2, pc_write=1, pc_source = bcond ? 10 : 00. Go to FETCH.
  - JAL (1101111): imm_sel=4, reg_write=1, wb_sel=10, pc_write=1, pc_source=10. Go to FETCH.
  - JALR (1100111): alu_op=00, alu_src_b=1, imm_sel=0, reg_write=1, wb_sel=10, pc_write=1, pc_source=01. Go to FETCH.
  - ECALL (1110011): if halt_cond, go to HALT with no pc_write. Otherwise pc_write=1, pc_source=00, go to FETCH.
  - Any other opcode: executes as a NOP. pc_write=1, pc_source=00, go to FETCH.
- MEM: i_or_d=1.
  - LOAD: mem_read=1. Go to WB on mem_ready.
  - STORE: mem_write=1. Also pc_write=mem_ready, pc_source=00. Go to FETCH on mem_ready.
- WB: reg_write=1, wb_sel = (LOAD ? 01 : 00), pc_write=1, pc_source=00. Go to FETCH.
- HALT: absorbing state. All strobes 0, is_halted=1. Only reset leaves it.
- instr_count increments by 1 on every cycle with pc_write=1 and wraps modulo 2^CNT_W.

## Timing
- Reset: while reset_n is low at a clock edge, the state becomes FETCH and instr_count becomes 0. While reset_n is low, all strobes are forced to 0 and is_halted=0. Reset mid-instruction abandons the instruction with no partial pc_write.
- Cycles per instruction, with no wait states:
  - BRANCH, JAL, JALR, ECALL, NOP: 3
  - R-type, I-type: 4
  - STORE: 4
  - LOAD: 5
- Each mem_ready-low cycle in FETCH or MEM adds one cycle. While waiting, the state and all strobes are held.
- Exactly one pc_write/retired pulse per instruction, in its final cycle. The counter is visible one cycle later.

## Configuration
- MULTICYCLE_MEM_WAIT_EN defined: FETCH and MEM wait on mem_ready as described above.
- MULTICYCLE_MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1. FETCH and MEM always take exactly one cycle.

## Test plan
- ADDI x1,x0,5 with mem_ready tied high → FETCH→DECODE→EXEC→WB. reg_write=1 in cycle 4 with imm_sel=0, alu_src_b=1. instr_count=1.
- LW with mem_ready low for 2 cycles in MEM → 7 total cycles. wb_sel=01 in WB. Exactly one retired pulse.
- BEQ with bcond=1 → pc_source=10 in EXEC. Same with bcond=0 → pc_source=00. Each takes 3 cycles.
- SLLI x2,x1,3 → imm_sel=5 in EXEC. SW → imm_sel=1, mem_write=1 only in MEM, pc_write coincident with mem_ready.
- ECALL with halt_cond=1 → is_halted=1 permanently, no further mem_read, instr_count unchanged. Then reset_n=0 for one cycle → state FETCH, is_halted=0, instr_count=0.
- Preload instr_count=0xFFFFFFFF (force) and retire a NOP → count wraps to 0. Opcode 0x7F → 3-cycle NOP with pc_source=00.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequencing FSM for the RV32I multicycle core. Steps each instruction
//   through FETCH/DECODE/EXEC/MEM/WB, drives every datapath strobe, counts
//   retired instructions and parks in HALT on a qualifying ECALL.
//
//   Optional feature macro: MULTICYCLE_MEM_WAIT_EN
//     defined   - FETCH and MEM stall while mem_ready is low
//     undefined - mem_ready is ignored; FETCH and MEM take one cycle
//
// Ports
//   clk, reset_n          core clock, synchronous active-low reset
//   opcode, funct3        IR fields (stable from DECODE to retirement)
//   mem_ready             memory handshake, access completes when high
//   bcond, halt_cond      ALU branch result / x17==10, valid in EXEC
//   i_or_d .. pc_source   datapath strobes (combinational from state/opcode)
//   retired               one-cycle pulse, same as pc_write
//   instr_count           retired-instruction counter, wraps
//   is_halted             high while in HALT
module multicycle_control_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    input  logic             bcond,
    input  logic             halt_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             is_halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        imm_sel   = 3'd0;
        pc_write  = 1'b0;
        pc_source = 2'b00;
        is_halted = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        alu_op    = 2'b10;
                        alu_src_b = 1'b1;
                        // SLLI / SRLI / SRAI take the shamt immediate
                        imm_sel   = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd5 : 3'd0;
                        state_d   = S_WB;
                    end
                    OP_LD: begin
                        alu_src_b = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_ST: begin
                        alu_src_b = 1'b1;
                        imm_sel   = 3'd1;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_op    = 2'b01;
                        imm_sel   = 3'd2;
                        pc_write  = 1'b1;
                        pc_source = bcond ? 2'b10 : 2'b00;
                        state_d   = S_FETCH;
                    end
                    OP_JAL: begin
                        imm_sel   = 3'd4;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 2'b10;
                        state_d   = S_FETCH;
                    end
                    OP_JALR: begin
                        alu_src_b = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'b10;
                        pc_write  = 1'b1;
                        pc_source = 2'b01;
                        state_d   = S_FETCH;
                    end
                    OP_SYS: begin
                        if (halt_cond) begin
                            state_d = S_HALT;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d = 1'b1;
                if (opcode == OP_LD) begin
                    mem_read = 1'b1;
                    if (rdy) state_d = S_WB;
                end else begin
                    // only stores reach MEM otherwise; they retire here
                    mem_write = 1'b1;
                    pc_write  = rdy;
                    if (rdy) state_d = S_FETCH;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LD) ? 2'b01 : 2'b00;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: is_halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // reset masks every strobe so an abandoned instruction cannot retire
        if (!reset_n) begin
            i_or_d    = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'b00;
            alu_src_b = 1'b0;
            alu_op    = 2'b00;
            imm_sel   = 3'd0;
            pc_write  = 1'b0;
            pc_source = 2'b00;
            is_halted = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pc_write) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign retired     = pc_write;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int unsigned CNT_W = 4;
`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [6:0]       opcode = OP_BAD;
    logic [2:0]       funct3 = 3'd0;
    logic             mem_ready = 1'b0;
    logic             bcond = 1'b0;
    logic             halt_cond = 1'b0;
    logic             i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]       wb_sel, alu_op, pc_source;
    logic             alu_src_b, pc_write, retired, is_halted;
    logic [2:0]       imm_sel;
    logic [CNT_W-1:0] instr_count;

    int unsigned      checks = 0;
    int unsigned      errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .mem_ready(mem_ready), .bcond(bcond), .halt_cond(halt_cond),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
        .pc_write(pc_write), .pc_source(pc_source), .retired(retired),
        .instr_count(instr_count), .is_halted(is_halted)
    );

    // bit 4 is pc_write, bit 1 retired, bit 0 is_halted
    logic [17:0] obs;
    assign obs = {i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel,
                  alu_src_b, alu_op, imm_sel, pc_write, pc_source, retired, is_halted};

    typedef struct {
        bit          rstn;
        bit          rdy;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        bc;
        logic        hc;
        bit          chk_cnt;
        logic [17:0] exp;
        string       tag;
    } step_t;

    step_t sbq[$];

    function automatic logic [17:0] ev(input logic iod, input logic mr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] wb,
                                       input logic asb, input logic [1:0] aop,
                                       input logic [2:0] imm, input logic pcw,
                                       input logic [1:0] pcs, input logic hlt);
        return {iod, mr, mw, irw, rw, wb, asb, aop, imm, pcw, pcs, pcw, hlt};
    endfunction

    task automatic push(input bit rstn, input bit rdy, input logic [6:0] op,
                        input logic [2:0] f3, input logic bc, input logic hc,
                        input bit chk, input logic [17:0] e, input string tag);
        step_t s;
        s.rstn = rstn; s.rdy = rdy; s.op = op; s.f3 = f3; s.bc = bc; s.hc = hc;
        s.chk_cnt = chk; s.exp = e; s.tag = tag;
        sbq.push_back(s);
    endtask

    // Queue the expected per-cycle strobes of one instruction.
    // fw/mw: mem_ready-low cycles in FETCH / MEM.
    task automatic build_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic bc, input logic hc,
                               input int unsigned fw, input int unsigned mw);
        logic [17:0] ex, mem_wait, mem_go, wbv;
        bit has_mem, has_wb;
        has_mem = 1'b0; has_wb = 1'b0;
        mem_wait = '0; mem_go = '0;
        wbv = ev(0,0,0,0,1,2'b00,0,2'b00,3'd0,1,2'b00,0);
        case (op)
            OP_R:    begin ex = ev(0,0,0,0,0,2'b00,0,2'b10,3'd0,0,2'b00,0); has_wb = 1'b1; end
            OP_I:    begin
                ex = ev(0,0,0,0,0,2'b00,1,2'b10,
                        (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0, 0,2'b00,0);
                has_wb = 1'b1;
            end
            OP_LD:   begin
                ex = ev(0,0,0,0,0,2'b00,1,2'b00,3'd0,0,2'b00,0);
                mem_wait = ev(1,1,0,0,0,2'b00,0,2'b00,3'd0,0,2'b00,0);
                mem_go = mem_wait;
                wbv = ev(0,0,0,0,1,2'b01,0,2'b00,3'd0,1,2'b00,0);
                has_mem = 1'b1; has_wb = 1'b1;
            end
            OP_ST:   begin
                ex = ev(0,0,0,0,0,2'b00,1,2'b00,3'd1,0,2'b00,0);
                mem_wait = ev(1,0,1,0,0,2'b00,0,2'b00,3'd0,0,2'b00,0);
                mem_go   = ev(1,0,1,0,0,2'b00,0,2'b00,3'd0,1,2'b00,0);
                has_mem = 1'b1;
            end
            OP_BR:   ex = ev(0,0,0,0,0,2'b00,0,2'b01,3'd2,1,bc ? 2'b10 : 2'b00,0);
            OP_JAL:  ex = ev(0,0,0,0,1,2'b10,0,2'b00,3'd4,1,2'b10,0);
            OP_JALR: ex = ev(0,0,0,0,1,2'b10,1,2'b00,3'd0,1,2'b01,0);
            OP_SYS:  ex = hc ? '0 : ev(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,2'b00,0);
            default: ex = ev(0,0,0,0,0,2'b00,0,2'b00,3'd0,1,2'b00,0);
        endcase

        if (WAIT_EN) begin
            for (int unsigned i = 0; i < fw; i++)
                push(1, 0, op, f3, bc, hc, 1, ev(0,1,0,0,0,2'b00,0,2'b00,3'd0,0,2'b00,0),
                     {tag, ".fetch_wait"});
            push(1, 1, op, f3, bc, hc, 1, ev(0,1,0,1,0,2'b00,0,2'b00,3'd0,0,2'b00,0),
                 {tag, ".fetch"});
        end else begin
            push(1, (fw > 0) ? 1'b0 : 1'b1, op, f3, bc, hc, 1,
                 ev(0,1,0,1,0,2'b00,0,2'b00,3'd0,0,2'b00,0), {tag, ".fetch"});
        end
        push(1, 1, op, f3, bc, hc, 1, '0, {tag, ".decode"});
        push(1, 1, op, f3, bc, hc, 1, ex, {tag, ".exec"});
        if (has_mem) begin
            if (WAIT_EN) begin
                for (int unsigned i = 0; i < mw; i++)
                    push(1, 0, op, f3, bc, hc, 1, mem_wait, {tag, ".mem_wait"});
                push(1, 1, op, f3, bc, hc, 1, mem_go, {tag, ".mem"});
            end else begin
                push(1, (mw > 0) ? 1'b0 : 1'b1, op, f3, bc, hc, 1, mem_go, {tag, ".mem"});
            end
        end
        if (has_wb) push(1, 1, op, f3, bc, hc, 1, wbv, {tag, ".wb"});
    endtask

    task automatic run_queue();
        step_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            @(negedge clk);
            reset_n = s.rstn; mem_ready = s.rdy; opcode = s.op;
            funct3 = s.f3; bcond = s.bc; halt_cond = s.hc;
            #1;
            checks++;
            if (obs !== s.exp) begin
                errors++;
                $display("FAIL %s strobes: got %b expected %b", s.tag, obs, s.exp);
            end
            if (s.chk_cnt) begin
                checks++;
                if (instr_count !== exp_cnt) begin
                    errors++;
                    $display("FAIL %s instr_count: got %0d expected %0d", s.tag, instr_count, exp_cnt);
                end
            end
            if (!s.rstn) exp_cnt = '0;
            else if (s.exp[4]) exp_cnt = exp_cnt + CNT_W'(1);
        end
    endtask

    task automatic test_reset();
        push(0, 1, OP_BAD, 3'd0, 0, 0, 0, '0, "reset0");
        push(0, 1, OP_BAD, 3'd0, 0, 0, 1, '0, "reset1");
        run_queue();
    endtask

    task automatic test_addi();
        build_instr("addi", OP_I, 3'b000, 0, 0, 0, 0);
        run_queue();
    endtask

    task automatic test_load_wait();
        build_instr("lw_wait", OP_LD, 3'b010, 0, 0, 0, 2);
        run_queue();
    endtask

    task automatic test_branch();
        build_instr("beq_taken", OP_BR, 3'b000, 1, 0, 0, 0);
        build_instr("beq_not", OP_BR, 3'b000, 0, 0, 0, 0);
        run_queue();
    endtask

    task automatic test_slli_sw();
        build_instr("slli", OP_I, 3'b001, 0, 0, 0, 0);
        build_instr("srai", OP_I, 3'b101, 0, 0, 0, 0);
        build_instr("sw_wait", OP_ST, 3'b010, 0, 0, 1, 3);
        run_queue();
    endtask

    task automatic test_halt();
        build_instr("ecall_halt", OP_SYS, 3'd0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            push(1, (i % 2) == 0, OP_SYS, 3'd0, 0, 1, 1,
                 ev(0,0,0,0,0,2'b00,0,2'b00,3'd0,0,2'b00,1), "halted");
        push(0, 1, OP_SYS, 3'd0, 0, 1, 1, '0, "halt_reset");
        build_instr("after_halt", OP_I, 3'b000, 0, 0, 0, 0);
        run_queue();
    endtask

    task automatic test_reset_mid();
        build_instr("lw_abort", OP_LD, 3'b010, 0, 0, 0, 0);
        while (sbq.size() > 3) void'(sbq.pop_back());
        push(0, 1, OP_LD, 3'd0, 0, 0, 1, '0, "mid_reset");
        build_instr("after_abort", OP_R, 3'd0, 0, 0, 0, 0);
        run_queue();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) build_instr("nop7f", OP_BAD, 3'd0, 0, 0, 0, 0);
        build_instr("post_wrap", OP_I, 3'd0, 0, 0, 0, 0);
        run_queue();
    endtask

    task automatic test_back_to_back();
        build_instr("b2b_r", OP_R, 3'd0, 0, 0, 2, 0);
        build_instr("b2b_jal", OP_JAL, 3'd0, 0, 0, 0, 0);
        build_instr("b2b_jalr", OP_JALR, 3'd0, 0, 0, 1, 0);
        build_instr("b2b_lw", OP_LD, 3'd2, 0, 0, 0, 0);
        build_instr("b2b_sw", OP_ST, 3'd2, 0, 0, 0, 0);
        build_instr("b2b_ecall", OP_SYS, 3'd0, 0, 0, 0, 0);
        build_instr("b2b_andi", OP_I, 3'b111, 0, 0, 0, 0);
        build_instr("b2b_bne", OP_BR, 3'b001, 1, 0, 0, 0);
        run_queue();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_branch();
        test_slli_sw();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
